// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    localparam logic [7:0] TAG_PC    = 8'h1E;
    localparam logic [7:0] TAG_INS   = 8'h1F;
    localparam logic [7:0] TAG_CLK   = 8'h20;
    localparam logic [7:0] TAG_FETCH = 8'h21;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, instruction} pairs.
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     valid,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE = (PW+1)'(1);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             full;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == FULL_CNT);
    assign valid = (count_q != '0);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Issue throttling upstream must make this unreachable.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst || flush)
        !(push && full && !pop)
    );

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch requester: owns the PC, issues to imem, buffers responses for decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int          FIFO_DEPTH   = 2,
    parameter logic [7:0]  TRACE_TAG    = TAG_FETCH
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READ_DATA,
    input  logic        IMEM_BUSYWAIT,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        D_READY,
    output logic        F_VALID,
    output logic [31:0] F_PC,
    output logic [31:0] F_INSTR,
    output logic [39:0] TRACE_OUT
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic         inflight_q, inflight_d;
    fetch_state_e state_q, state_d;

    logic [CW-1:0] count;
    logic          buf_valid;
    logic          pop, push, issue_en, accept;
    fetch_entry_t  head, push_entry;

    // A redirect suppresses every other buffer/issue action that cycle.
    assign pop  = buf_valid && D_READY && !BRANCH_TAKEN;
    assign push = inflight_q && !BRANCH_TAKEN;

    assign issue_en = (32'(count) + 32'(inflight_q) + 32'd1)
                   <= (32'(FIFO_DEPTH) + 32'(pop));
    assign accept = issue_en && !IMEM_BUSYWAIT && !BRANCH_TAKEN;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        state_d       = state_q;
        if (BRANCH_TAKEN) begin
            pc_d    = align_word(BRANCH_TARGET);
            state_d = ST_REDIRECT;
        end else begin
            if (accept) begin
                pc_d          = pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            unique case (state_q)
                ST_RUN, ST_STALL, ST_REDIRECT:
                    state_d = accept ? ST_RUN : ST_STALL;
                default:
                    state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q          <= RESET_VECTOR;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_VECTOR;
            state_q       <= ST_RUN;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            state_q       <= state_d;
        end
    end

    assign push_entry.pc    = inflight_pc_q;
    assign push_entry.instr = IMEM_READ_DATA;

    fetch_buffer #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fetch_buffer (
        .clk       (CLK),
        .rst       (RESET),
        .flush     (BRANCH_TAKEN),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .valid     (buf_valid),
        .head      (head),
        .count     (count)
    );

    assign IMEM_ADDRESS = pc_q;
    assign F_VALID      = buf_valid;
    assign F_PC         = buf_valid ? head.pc : 32'h0;
    assign F_INSTR      = buf_valid ? head.instr : 32'h0;
    assign TRACE_OUT    = {pc_q, TRACE_TAG};

endmodule
